cl_ddr_stat_arb: RTL

//  Round-robin arbiter/sequencer sharing one sh_ddr stat (config/status) register port between NUM_REQ requesters.

---
 rtl/cl_ddr_stat_arb.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cl_ddr_stat_arb.sv
// Round-robin arbiter sharing one sh_ddr stat register port between NUM_REQ requesters.
// One transaction in flight at a time; a missing ack is closed out by a timeout error response.
module cl_ddr_stat_arb #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst_main_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         stat_addr,
    output logic                      stat_wr,
    output logic                      stat_rd,
    output logic [31:0]               stat_wdata,
    input  logic                      stat_ack,
    input  logic [31:0]               stat_rdata,
    input  logic [7:0]                stat_int,
    output logic [7:0]                int_out
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    localparam logic [31:0] TimeoutData = 32'hDEAD_DEAD;

    logic [1:0]         state_q, state_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0]  stat_addr_q, stat_addr_d;
    logic [31:0]        stat_wdata_q, stat_wdata_d;
    logic               stat_wr_q, stat_wr_d;
    logic               stat_rd_q, stat_rd_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;
    logic [7:0]         int_q, int_d;

    logic               gnt_found;
    logic [IdxW-1:0]    gnt_idx;
    logic [IdxW-1:0]    cand;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [NUM_REQ-1:0] rsp_oh;

    // Scan starts one past the last winner so every holder is served within NUM_REQ grants.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr_q;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IdxW'((32'(rr_ptr_q) + off) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        gnt_oh          = '0;
        gnt_oh[gnt_idx] = 1'b1;
        rsp_oh           = '0;
        rsp_oh[rr_ptr_q] = 1'b1;
    end

    // Reset also masks the combinational accept so nothing is granted while held in reset.
    assign req_ready = (rst_main_n && state_q == StIdle && gnt_found) ? gnt_oh : '0;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        cmd_wr_d     = cmd_wr_q;
        stat_addr_d  = stat_addr_q;
        stat_wdata_d = stat_wdata_q;
        stat_wr_d    = 1'b0;
        stat_rd_d    = 1'b0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    rr_ptr_d     = gnt_idx;
                    cmd_wr_d     = req_wr[gnt_idx];
                    stat_addr_d  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
                    stat_wdata_d = req_wdata[gnt_idx*32 +: 32];
                    stat_wr_d    = req_wr[gnt_idx];
                    stat_rd_d    = !req_wr[gnt_idx];
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                cnt_d = '0;
                if (stat_ack) begin
                    rsp_valid_d = rsp_oh;
                    rsp_rdata_d = cmd_wr_q ? 32'h0 : stat_rdata;
                    rsp_err_d   = 1'b0;
                    state_d     = StResp;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (stat_ack) begin
                    rsp_valid_d = rsp_oh;
                    rsp_rdata_d = cmd_wr_q ? 32'h0 : stat_rdata;
                    rsp_err_d   = 1'b0;
                    state_d     = StResp;
                end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    rsp_valid_d = rsp_oh;
                    rsp_rdata_d = TimeoutData;
                    rsp_err_d   = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign int_d = stat_int;

    always_ff @(posedge clk or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q      <= StIdle;
            rr_ptr_q     <= IdxW'(NUM_REQ - 1);
            cnt_q        <= '0;
            cmd_wr_q     <= 1'b0;
            stat_addr_q  <= '0;
            stat_wdata_q <= '0;
            stat_wr_q    <= 1'b0;
            stat_rd_q    <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            int_q        <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            cmd_wr_q     <= cmd_wr_d;
            stat_addr_q  <= stat_addr_d;
            stat_wdata_q <= stat_wdata_d;
            stat_wr_q    <= stat_wr_d;
            stat_rd_q    <= stat_rd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            int_q        <= int_d;
        end
    end

    assign stat_addr  = stat_addr_q;
    assign stat_wdata = stat_wdata_q;
    assign stat_wr    = stat_wr_q;
    assign stat_rd    = stat_rd_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign int_out    = int_q;

endmodule
